// File: rtl/change_dump_capture.sv
// Hardware value-change recorder: timestamps probe changes, snapshots and overflow
// markers into a first-word-fall-through FIFO drained over a valid/ready stream.
module change_dump_capture #(
    parameter int DATA_W = 16,
    parameter int TIME_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          probe,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TIME_W-1:0]          out_time,
    output logic [DATA_W-1:0]          out_value,
    output logic [1:0]                 out_kind,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DATA_W-1:0]          dropped
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int REC_W = TIME_W + DATA_W + 2;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [TIME_W-1:0] timer;
    logic [DATA_W-1:0] prev;
    logic              en_q;
    logic              pending;

    logic              snap;
    logic              chg;
    logic              evt;
    logic              pop;
    logic              space;
    logic              push;
    logic [REC_W-1:0]  push_data;
    logic [DATA_W-1:0] dropped_nxt;
    logic              pending_nxt;

    assign out_valid = (level != '0);
    assign {out_time, out_value, out_kind} = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        snap        = enable & (~en_q | flush);
        chg         = enable & en_q & (probe != prev) & ~snap;
        evt         = snap | chg;
        pop         = out_valid & out_ready;
        space       = (level < LW'(DEPTH)) | pop;
        push        = 1'b0;
        push_data   = '0;
        dropped_nxt = dropped;
        pending_nxt = pending;
        // A waiting overflow marker outranks new events; an event colliding with it is itself lost.
        if (pending && space) begin
            push        = 1'b1;
            push_data   = {timer, dropped, 2'd2};
            dropped_nxt = evt ? DATA_W'(1) : '0;
            pending_nxt = evt;
        end else if (evt && space) begin
            push        = 1'b1;
            push_data   = {timer, probe, snap ? 2'd1 : 2'd0};
        end else if (evt) begin
            dropped_nxt = (dropped == '1) ? dropped : dropped + DATA_W'(1);
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            prev    <= '0;
            en_q    <= 1'b0;
            pending <= 1'b0;
            dropped <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
        end else begin
            timer   <= timer + TIME_W'(1);
            prev    <= probe;
            en_q    <= enable;
            pending <= pending_nxt;
            dropped <= dropped_nxt;
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule
